// File: rtl/distance_sort_seq.sv
// Sequential odd-even transposition sorter of N (distance, type) pairs, one phase per clock,
// with valid/ready handshakes and early exit. Optional majority vote over the first K: KNN_VOTE_EN.

module distance_sort_cmp #(
    parameter int DW = 16
) (
    input  logic [DW-1:0] d_lo,
    input  logic [DW-1:0] d_hi,
    input  logic          descending,
    output logic          swap
);
    // Strict compare so equal distances never move (stable sort)
    assign swap = descending ? (d_lo < d_hi) : (d_lo > d_hi);
endmodule

module distance_sort_seq #(
    parameter int N  = 8,
    parameter int DW = 16,
    parameter int TW = 4,
    parameter int K  = 3
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            descending,
    input  logic [N*DW-1:0] distance_in,
    input  logic [N*TW-1:0] type_in,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [N*DW-1:0] distance_out,
    output logic [N*TW-1:0] type_out,
`ifdef KNN_VOTE_EN
    output logic [TW-1:0]   vote_type,
`endif
    output logic            busy
);
    localparam int CW = $clog2(N + 1);

`ifdef KNN_VOTE_EN
    typedef enum logic [1:0] {IDLE, SORT, VOTE, DONE} state_t;
`else
    typedef enum logic [1:0] {IDLE, SORT, DONE} state_t;
`endif

    state_t                 state, state_nxt;
    logic [N-1:0][DW-1:0]   d_q, d_nxt;
    logic [N-1:0][TW-1:0]   t_q, t_nxt;
    logic                   desc_q;
    logic [CW-1:0]          cnt_q;
    logic                   streak_q;
    logic [N-2:0]           swap_req, swap;
    logic                   any_swap, stop, accept, out_load;

    assign in_ready  = (state == IDLE);
    assign busy      = (state == SORT);
    assign out_valid = (state == DONE);
    assign accept    = in_valid && in_ready;

    // One comparator per adjacent pair; phase parity selects which pairs act
    for (genvar i = 0; i < N - 1; i++) begin : g_lane
        distance_sort_cmp #(.DW(DW)) u_cmp (
            .d_lo       (d_q[i]),
            .d_hi       (d_q[i+1]),
            .descending (desc_q),
            .swap       (swap_req[i])
        );
        assign swap[i] = swap_req[i] && (cnt_q[0] == 1'(i % 2));
    end

    always_comb begin
        d_nxt = d_q;
        t_nxt = t_q;
        for (int i = 0; i < N - 1; i++) begin
            if (swap[i]) begin
                d_nxt[i]   = d_q[i+1];
                d_nxt[i+1] = d_q[i];
                t_nxt[i]   = t_q[i+1];
                t_nxt[i+1] = t_q[i];
            end
        end
    end

    assign any_swap = |swap;
    // Two quiet phases in a row (both parities) means the vector is already ordered
    assign stop     = (cnt_q == CW'(N - 1)) || (!any_swap && streak_q);

`ifdef KNN_VOTE_EN
    localparam int VW = $clog2(K + 1);
    logic [K-1:0][VW-1:0] vcnt;
    logic [VW-1:0]        best_cnt;
    logic [TW-1:0]        vote_nxt;

    // Strict '>' while scanning upward keeps the earliest type on a tie
    always_comb begin
        vcnt     = '0;
        best_cnt = '0;
        vote_nxt = t_q[0];
        for (int i = 0; i < K; i++)
            for (int j = 0; j < K; j++)
                if (t_q[j] == t_q[i]) vcnt[i] = vcnt[i] + VW'(1);
        for (int i = 0; i < K; i++) begin
            if (vcnt[i] > best_cnt) begin
                best_cnt = vcnt[i];
                vote_nxt = t_q[i];
            end
        end
    end
`endif

    always_comb begin
        state_nxt = state;
        out_load  = 1'b0;
        case (state)
            IDLE: if (accept) state_nxt = SORT;
`ifdef KNN_VOTE_EN
            SORT: if (stop) state_nxt = VOTE;
            VOTE: begin
                state_nxt = DONE;
                out_load  = 1'b1;
            end
`else
            SORT: if (stop) begin
                state_nxt = DONE;
                out_load  = 1'b1;
            end
`endif
            DONE: if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            d_q          <= '0;
            t_q          <= '0;
            desc_q       <= 1'b0;
            cnt_q        <= '0;
            streak_q     <= 1'b0;
            distance_out <= '0;
            type_out     <= '0;
`ifdef KNN_VOTE_EN
            vote_type    <= '0;
`endif
        end else begin
            if (accept) begin
                d_q      <= distance_in;
                t_q      <= type_in;
                desc_q   <= descending;
                cnt_q    <= '0;
                streak_q <= 1'b0;
            end else if (state == SORT) begin
                d_q      <= d_nxt;
                t_q      <= t_nxt;
                cnt_q    <= cnt_q + CW'(1);
                streak_q <= !any_swap;
            end
            if (out_load) begin
`ifdef KNN_VOTE_EN
                distance_out <= d_q;
                type_out     <= t_q;
                vote_type    <= vote_nxt;
`else
                distance_out <= d_nxt;
                type_out     <= t_nxt;
`endif
            end
        end
    end
endmodule

// File: tb/tb_distance_sort_seq.sv
// Scoreboard bench for distance_sort_seq (N=4, DW=8, TW=4, K=3); build with KNN_VOTE_EN to also check vote_type.

module tb_distance_sort_seq;
    localparam int N = 4, DW = 8, TW = 4, K = 3;
`ifdef KNN_VOTE_EN
    localparam int VL = 1;
`else
    localparam int VL = 0;
`endif

    logic            clk = 1'b0;
    logic            rst_n, in_valid, in_ready, descending, out_valid, out_ready, busy;
    logic [N*DW-1:0] distance_in, distance_out;
    logic [N*TW-1:0] type_in, type_out;
`ifdef KNN_VOTE_EN
    logic [TW-1:0]   vote_type;
`endif

    always #5 clk = ~clk;

    distance_sort_seq #(.N(N), .DW(DW), .TW(TW), .K(K)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .descending   (descending),
        .distance_in  (distance_in),
        .type_in      (type_in),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .distance_out (distance_out),
        .type_out     (type_out),
`ifdef KNN_VOTE_EN
        .vote_type    (vote_type),
`endif
        .busy         (busy)
    );

    typedef struct {
        logic [N*DW-1:0] d;
        logic [N*TW-1:0] t;
        logic [TW-1:0]   v;
    } exp_t;

    exp_t sb[$];
    int   nvec = 0;
    int   nerr = 0;

    function automatic logic [N*DW-1:0] pd(int a0, int a1, int a2, int a3);
        return {DW'(a3), DW'(a2), DW'(a1), DW'(a0)};
    endfunction

    function automatic logic [N*TW-1:0] pt(int a0, int a1, int a2, int a3);
        return {TW'(a3), TW'(a2), TW'(a1), TW'(a0)};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: compares every accepted result against the head of the scoreboard
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_result", 64'd1, 64'd0);
            end else begin
                e = sb.pop_front();
                check("distance_out", 64'(distance_out), 64'(e.d));
                check("type_out", 64'(type_out), 64'(e.t));
`ifdef KNN_VOTE_EN
                check("vote_type", 64'(vote_type), 64'(e.v));
`endif
            end
        end
    end

    task automatic send(input logic [N*DW-1:0] d, input logic [N*TW-1:0] t, input logic desc,
                        input bit push, input exp_t e);
        int k = 0;
        while (!in_ready && k < 50) begin
            tick();
            k++;
        end
        check("in_ready_timeout", 64'(in_ready), 64'd1);
        distance_in = d;
        type_in     = t;
        descending  = desc;
        in_valid    = 1'b1;
        if (push) sb.push_back(e);
        tick();
        // Scramble inputs after acceptance; they must not matter
        in_valid    = 1'b0;
        distance_in = '1;
        type_in     = '1;
        descending  = ~desc;
    endtask

    task automatic wait_done(output int lat, output int bc);
        lat = 0;
        bc  = 0;
        while (!out_valid && lat < 20) begin
            if (busy) bc++;
            tick();
            lat++;
        end
        check("out_valid_timeout", 64'(out_valid), 64'd1);
    endtask

    initial begin
        exp_t e;
        int   lat, bc;

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; descending = 1'b0;
        distance_in = '0; type_in = '0;
        tick();
        tick();
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_distance_out", 64'(distance_out), 64'd0);
        check("rst_type_out", 64'(type_out), 64'd0);
        rst_n = 1'b1;
        tick();
        check("rst_in_ready", 64'(in_ready), 64'd1);

        // Ascending
        e = '{pd(1,3,7,9), pt(3,1,2,0), 4'd3};
        send(pd(9,3,7,1), pt(0,1,2,3), 1'b0, 1'b1, e);
        wait_done(lat, bc);
        check("asc_latency", 64'(lat), 64'(4 + VL));
        tick();

        // Descending
        e = '{pd(9,7,3,1), pt(0,2,1,3), 4'd0};
        send(pd(9,3,7,1), pt(0,1,2,3), 1'b1, 1'b1, e);
        wait_done(lat, bc);
        check("desc_latency", 64'(lat), 64'(4 + VL));
        tick();

        // Equal distances keep input order
        e = '{pd(2,5,5,5), pt(3,1,2,4), 4'd3};
        send(pd(5,5,2,5), pt(1,2,3,4), 1'b0, 1'b1, e);
        wait_done(lat, bc);
        tick();

        // Presorted: early exit after two quiet phases
        e = '{pd(1,2,3,4), pt(5,9,9,1), 4'd9};
        send(pd(1,2,3,4), pt(5,9,9,1), 1'b0, 1'b1, e);
        wait_done(lat, bc);
        check("presorted_latency", 64'(lat), 64'(2 + VL));
        check("presorted_busy_cycles", 64'(bc), 64'd2);
        tick();

        // Backpressure with in_valid pulsing in DONE
        out_ready = 1'b0;
        e = '{pd(2,4,6,8), pt(2,0,3,1), 4'd2};
        send(pd(4,8,2,6), pt(0,1,2,3), 1'b0, 1'b1, e);
        wait_done(lat, bc);
        for (int c = 0; c < 5; c++) begin
            in_valid    = c[0];
            distance_in = pd(1,1,1,1);
            type_in     = pt(7,7,7,7);
            check("bp_out_valid", 64'(out_valid), 64'd1);
            check("bp_in_ready", 64'(in_ready), 64'd0);
            check("bp_distance_hold", 64'(distance_out), 64'(pd(2,4,6,8)));
            check("bp_type_hold", 64'(type_out), 64'(pt(2,0,3,1)));
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        check("bp_release_out_valid", 64'(out_valid), 64'd0);
        check("bp_release_in_ready", 64'(in_ready), 64'd1);
        check("bp_release_busy", 64'(busy), 64'd0);
        check("idle_distance_hold", 64'(distance_out), 64'(pd(2,4,6,8)));
        tick();
        check("idle_no_load", 64'(busy), 64'd0);

        // Reset on the 2nd SORT cycle
        send(pd(9,3,7,1), pt(0,1,2,3), 1'b0, 1'b0, e);
        check("midrst_busy_pre", 64'(busy), 64'd1);
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_in_ready", 64'(in_ready), 64'd1);
        check("midrst_distance_out", 64'(distance_out), 64'd0);
        check("midrst_type_out", 64'(type_out), 64'd0);

        // Fresh vector after reset
        e = '{pd(255,200,30,10), pt(7,5,8,6), 4'd7};
        send(pd(200,10,255,30), pt(5,6,7,8), 1'b1, 1'b1, e);
        wait_done(lat, bc);
        check("post_rst_latency", 64'(lat), 64'(4 + VL));
        tick();
        tick();

        check("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/distance_sort_seq.md
Name: distance_sort_seq

Overview:
- Sequential, parametrised sorter for the KNN datapath. It takes a full vector of N (distance, type) pairs and sorts them by distance using odd-even transposition, one phase per clock.
- Compared with the combinational N-stage network it replaces, it adds:
  - valid/ready handshakes on input and output;
  - independent distance and type widths;
  - a runtime ascending/descending select;
  - data-dependent early termination.
- Sits between the distance computation stage and the K-selection/vote stage.

Parameters:
- N, 8, number of elements sorted; N >= 2.
- DW, 16, distance width in bits (unsigned).
- TW, 4, type/label width in bits.
- K, 3, neighbour count used by the optional vote; 1 <= K <= N.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst_n  in  1  synchronous reset, active-low.
- in_valid  in  1  input vector valid.
- in_ready  out  1  block can accept a vector; combinational, equals (state==IDLE).
- descending  in  1  sampled at acceptance; 0 = smallest distance first, 1 = largest first.
- distance_in  in  N*DW  element i at [i*DW +: DW].
- type_in  in  N*TW  element i at [i*TW +: TW].
- out_valid  out  1  sorted result valid.
- out_ready  in  1  consumer accepts result.
- distance_out  out  N*DW  sorted distances, same packing as distance_in.
- type_out  out  N*TW  types permuted identically to the distances.
- busy  out  1  high in SORT state.

Behaviour:
- Reset: while rst_n=0 at a clock edge:
  - state <= IDLE;
  - out_valid, busy, distance_out, type_out, all internal registers and counters <= 0.
  - Reset wins over every other event, including mid-SORT and an unconsumed DONE.
- States: IDLE, SORT, DONE.
- IDLE:
  - Acceptance: in_valid && in_ready at edge A.
  - On acceptance, load the element registers from distance_in/type_in and latch descending.
  - Clear the phase counter (width $clog2(N+1)) and the no-swap streak; go to SORT.
- SORT: each edge executes one phase on the registers.
  - Even phase (counter bit0 = 0): compare pairs (0,1),(2,3),…
  - Odd phase: compare pairs (1,2),(3,4),…
  - Unpaired end elements pass through unchanged (this covers odd N).
  - Swap rule, ascending: swap when d[lo] > d[hi] (strict).
  - Swap rule, descending: swap when d[lo] < d[hi] (strict).
  - Strict compare keeps the sort stable: equal distances keep their input order.
  - Types always move with their distances.
  - Leave SORT for DONE after the edge on which either:
    - the phase count reaches N; or
    - two consecutive phases performed zero swaps.
  - If p is the number of phases executed, then 2 <= p <= N (p = N when N = 2), and out_valid rises after edge A+p.
- DONE:
  - out_valid = 1; distance_out and type_out are registered copies and stay stable until handshake.
  - On out_valid && out_ready, go to IDLE next cycle. in_ready is 0 in DONE, so back-to-back vectors incur one IDLE cycle.
- Ignored inputs: in_valid outside IDLE is ignored; no input is sampled.
- Held signals: descending and input data changes after acceptance have no effect.
- out_ready while not out_valid is ignored.
- distance_out and type_out hold their last result in IDLE and SORT; they update only on the SORT→DONE transition.
- All comparisons are unsigned, DW bits; no arithmetic widening is required.

Optional Feature:
- Macro: KNN_VOTE_EN.
- Defined:
  - Adds output port vote_type (TW bits) and an extra state VOTE between SORT and DONE, lasting 1 cycle.
  - VOTE counts occurrences of each of the first K sorted types (counter width $clog2(K+1)).
  - vote_type = the type with the highest count.
  - Tie → the type whose first occurrence has the lowest sorted index.
  - vote_type is valid with out_valid and reset to 0.
  - Latency increases by 1.
- Not defined: no vote_type port, no VOTE state; SORT goes directly to DONE.

Test Plan:
- Reset: hold rst_n=0 two edges, then release → out_valid=0, busy=0, outputs 0, in_ready=1.
- Ascending sort (N=4, DW=8, TW=4): distances {9,3,7,1}, types {0,1,2,3}, descending=0 → distances {1,3,7,9}, types {3,1,2,0}; out_valid within 4 edges of A. With KNN_VOTE_EN and K=3 → vote_type=3.
- Descending sort: same input with descending=1 → distances {9,7,3,1}, types {0,2,1,3}.
- Stability and early exit:
  - Ties: distances {5,5,2,5}, types {1,2,3,4} → {2,5,5,5}, types {3,1,2,4}.
  - Presorted input {1,2,3,4} → out_valid after edge A+2, busy high exactly 2 cycles.
- Backpressure: hold out_ready=0 for 5 cycles with in_valid pulsing → outputs and out_valid stable, in_ready=0, no new vector loaded. Then out_ready=1 → IDLE next cycle, in_ready=1.
- Reset mid-operation: rst_n=0 on the 2nd SORT cycle → next cycle IDLE, out_valid=0, outputs 0. A fresh vector then sorts correctly.
